// File: rtl/mts_sysref_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mts_sysref_pkg
// Brief    : Shared types and default widths for the PL SYSREF generator.
// Revision : 1.0 - initial release
// ============================================================================
package mts_sysref_pkg;

  localparam int C_DEF_CNT_W    = 16;
  localparam int C_DEF_NCNT_W   = 8;
  localparam int C_DEF_SYNC_FFS = 3;

  // WAIT_REF is only reachable when reference alignment is compiled in.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REF = 2'd1,
    RUN      = 2'd2
  } sysref_gen_state_t;

endpackage
`default_nettype wire

// File: rtl/mts_sysref_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : mts_sysref_edge_det
// Brief    : Synchronises an asynchronous reference SYSREF onto pl_clk and
//            emits a registered one-cycle pulse on each rising edge.
//            Pin edge to rise high = SYNC_FFS+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mts_sysref_edge_det
  import mts_sysref_pkg::*;
#(
  parameter int SYNC_FFS = C_DEF_SYNC_FFS
) (
  input  logic pl_clk,
  input  logic pl_rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_FFS-1:0] sync_q;
  logic [SYNC_FFS-1:0] sync_d;
  logic                prev_q;
  logic                prev_d;
  logic                rise_q;
  logic                rise_d;

  generate
    if (SYNC_FFS == 1) begin : g_sync_single
      assign sync_d = async_in;
    end else begin : g_sync_chain
      assign sync_d = {sync_q[SYNC_FFS-2:0], async_in};
    end
  endgenerate

  assign prev_d = sync_q[SYNC_FFS-1];
  assign rise_d = sync_q[SYNC_FFS-1] & ~prev_q;

  // Synchroniser chain, previous-value flop and registered edge pulse.
  always_ff @(posedge pl_clk or negedge pl_rst_n) begin
    if (!pl_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/mts_pl_sysref_gen.sv
`default_nettype none
// ============================================================================
// Module   : mts_pl_sysref_gen
// Brief    : PL-side SYSREF pulse-train generator for multi-tile sync.
//            Burst of cfg_count pulses, or continuous when cfg_count==0.
//            Optional build macro MTS_SYSREF_GEN_ALIGN_EN aligns the first
//            pulse to a rising edge of the captured reference SYSREF.
// Revision : 1.0 - initial release
// ============================================================================
module mts_pl_sysref_gen
  import mts_sysref_pkg::*;
#(
  parameter int CNT_W    = C_DEF_CNT_W,
  parameter int NCNT_W   = C_DEF_NCNT_W,
  parameter int SYNC_FFS = C_DEF_SYNC_FFS
) (
  input  logic              pl_clk,
  input  logic              pl_rst_n,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [NCNT_W-1:0] cfg_count,
  input  logic              start,
  input  logic              stop,
  input  logic              ref_sysref,
  output logic              sysref_out,
  output logic              busy,
  output logic              done,
  output logic [NCNT_W-1:0] pulse_cnt
);

  sysref_gen_state_t state_q;
  sysref_gen_state_t state_d;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  period_d;
  logic [CNT_W-1:0]  high_q;
  logic [CNT_W-1:0]  high_d;
  logic [CNT_W-1:0]  phase_q;
  logic [CNT_W-1:0]  phase_d;
  logic [NCNT_W-1:0] count_q;
  logic [NCNT_W-1:0] count_d;
  logic [NCNT_W-1:0] pulse_cnt_q;
  logic [NCNT_W-1:0] pulse_cnt_d;
  logic              sysref_q;
  logic              sysref_d;
  logic              done_q;
  logic              done_d;

  logic [CNT_W-1:0]  w_high_clamp;
  logic [CNT_W-1:0]  w_phase_next;
  logic [NCNT_W-1:0] w_cnt_inc;
  logic              w_period_end;
  logic              w_last_period;

`ifdef MTS_SYSREF_GEN_ALIGN_EN
  logic w_ref_rise;

  mts_sysref_edge_det #(
    .SYNC_FFS (SYNC_FFS)
  ) u_ref_edge (
    .pl_clk   (pl_clk),
    .pl_rst_n (pl_rst_n),
    .async_in (ref_sysref),
    .rise     (w_ref_rise)
  );
`else
  // Reference input and synchroniser depth are not used without alignment.
  logic w_unused_ref;
  localparam int C_UNUSED_SYNC_FFS = SYNC_FFS;
  assign w_unused_ref = ref_sysref;
`endif

  // High time is clamped to the period so every period keeps a low cycle.
  assign w_high_clamp  = (cfg_high > cfg_period) ? cfg_period : cfg_high;
  assign w_period_end  = (phase_q == period_q);
  assign w_phase_next  = w_period_end ? '0 : phase_q + 1'b1;
  assign w_cnt_inc     = (&pulse_cnt_q) ? pulse_cnt_q : pulse_cnt_q + 1'b1;
  assign w_last_period = (count_q != '0) && (pulse_cnt_q == count_q - 1'b1);

  // Next-state, counter and output decode; everything holds unless changed.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    high_d      = high_q;
    count_d     = count_q;
    phase_d     = phase_q;
    pulse_cnt_d = pulse_cnt_q;
    sysref_d    = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // stop sampled together with start suppresses the run entirely.
        if (start && !stop) begin
          period_d    = cfg_period;
          high_d      = w_high_clamp;
          count_d     = cfg_count;
          phase_d     = '0;
          pulse_cnt_d = '0;
`ifdef MTS_SYSREF_GEN_ALIGN_EN
          state_d     = WAIT_REF;
`else
          state_d     = RUN;
          sysref_d    = (w_high_clamp != '0);
`endif
        end
      end

`ifdef MTS_SYSREF_GEN_ALIGN_EN
      WAIT_REF: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (w_ref_rise) begin
          state_d  = RUN;
          phase_d  = '0;
          sysref_d = (high_q != '0);
        end
      end
`endif

      RUN: begin
        // Burst end takes precedence so a coincident stop still reports
        // the full count and only one done pulse.
        if (w_period_end && w_last_period) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          pulse_cnt_d = count_q;
        end else if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d  = w_phase_next;
          sysref_d = (w_phase_next < high_q);
          if (w_period_end) begin
            pulse_cnt_d = w_cnt_inc;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge pl_clk or negedge pl_rst_n) begin
    if (!pl_rst_n) begin
      state_q     <= IDLE;
      period_q    <= '0;
      high_q      <= '0;
      count_q     <= '0;
      phase_q     <= '0;
      pulse_cnt_q <= '0;
      sysref_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      high_q      <= high_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      pulse_cnt_q <= pulse_cnt_d;
      sysref_q    <= sysref_d;
      done_q      <= done_d;
    end
  end

  assign sysref_out = sysref_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign pulse_cnt  = pulse_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mts_pl_sysref_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mts_pl_sysref_gen
// Brief    : Self-checking bench for mts_pl_sysref_gen. Expected outputs come
//            from an arithmetic model indexed by cycles since start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mts_pl_sysref_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic [7:0]  cfg_count = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ref_sysref = 1'b0;
  logic        sysref_out;
  logic        busy;
  logic        done;
  logic [7:0]  pulse_cnt;

  int vectors = 0;
  int errors  = 0;

  mts_pl_sysref_gen #(
    .CNT_W    (16),
    .NCNT_W   (8),
    .SYNC_FFS (3)
  ) dut (
    .pl_clk     (clk),
    .pl_rst_n   (rst_n),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .ref_sysref (ref_sysref),
    .sysref_out (sysref_out),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Index of the first idle cycle of a run (j counted from 0 at the first
  // cycle after start is accepted). s < 0 means no stop is issued.
  function automatic int run_end(input int p, input int n, input int s);
    int nat;
    nat = (n != 0) ? n * (p + 1) : 32'h3fff_ffff;
    if (s >= 0 && s + 1 < nat) return s + 1;
    return nat;
  endfunction

  // Expected {sysref_out, busy, done, pulse_cnt} at run cycle j.
  function automatic logic [10:0] model(input int j, input int p, input int hc,
                                        input int n, input int s);
    int         l;
    int         h;
    int         jend;
    int         cnt;
    bit         stopped;
    logic [7:0] c8;
    l       = p + 1;
    h       = (hc < p) ? hc : p;
    jend    = run_end(p, n, s);
    stopped = (n == 0) || (jend < n * l);
    if (j < jend) begin
      c8 = 8'(sat(j / l));
      return {((j % l) < h), 1'b1, 1'b0, c8};
    end
    cnt = stopped ? sat(s / l) : n;
    c8  = 8'(cnt);
    return {1'b0, 1'b0, (j == jend), c8};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sysref_out, busy, done, pulse_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_hold: got %b/%b/%b/%0d, expected 0/0/0/0",
               sysref_out, busy, done, pulse_cnt);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({sysref_out, busy, done, pulse_cnt} !== 11'd0) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %b/%b/%b/%0d, expected 0/0/0/0",
                 k, sysref_out, busy, done, pulse_cnt);
      end
    end
  endtask

`ifdef MTS_SYSREF_GEN_ALIGN_EN

  task automatic test_align();
    logic [10:0] e;
    logic [10:0] o;
    @(negedge clk);
    cfg_period = 16'd9; cfg_high = 16'd2; cfg_count = 8'd1; start = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      start = 1'b0;
      o = {sysref_out, busy, done, pulse_cnt};
      e = (k < 25) ? {1'b0, 1'b1, 1'b0, 8'd0} : model(k - 25, 9, 2, 1, -1);
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL align cycle %0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                 k, o[10], o[9], o[8], o[7:0], e[10], e[9], e[8], e[7:0]);
      end
      if (k == 20) ref_sysref = 1'b1;
    end
    ref_sysref = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_align_stop();
    logic [10:0] e;
    logic [10:0] o;
    @(negedge clk);
    cfg_period = 16'd5; cfg_high = 16'd1; cfg_count = 8'd0; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      o = {sysref_out, busy, done, pulse_cnt};
      e = (k <= 5) ? {1'b0, 1'b1, 1'b0, 8'd0} :
          (k == 6) ? {1'b0, 1'b0, 1'b1, 8'd0} : 11'd0;
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL align_stop cycle %0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                 k, o[10], o[9], o[8], o[7:0], e[10], e[9], e[8], e[7:0]);
      end
      stop = (k == 5);
    end
    stop = 1'b0;
  endtask

`else

  // One run from start to a few cycles past its end; optionally scrambles
  // cfg_* during the run to show they are ignored once latched.
  task automatic test_run(input string name, input int p, input int hc,
                          input int n, input int s, input bit scramble);
    logic [10:0] e;
    logic [10:0] o;
    int          jend;
    int          ndone;
    jend  = run_end(p, n, s);
    ndone = 0;
    @(negedge clk);
    cfg_period = 16'(p); cfg_high = 16'(hc); cfg_count = 8'(n);
    start = 1'b1; stop = 1'b0;
    for (int k = 1; k <= jend + 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      o = {sysref_out, busy, done, pulse_cnt};
      e = model(k - 1, p, hc, n, s);
      if (done === 1'b1) ndone++;
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s P=%0d H=%0d N=%0d cycle %0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                 name, p, hc, n, k, o[10], o[9], o[8], o[7:0], e[10], e[9], e[8], e[7:0]);
      end
      stop = (k - 1 == s);
      if (scramble) begin
        cfg_period = 16'($urandom);
        cfg_high   = 16'($urandom);
        cfg_count  = 8'($urandom);
      end
    end
    stop = 1'b0;
    vectors++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d, expected 1", name, ndone);
    end
  endtask

  task automatic test_start_stop_idle();
    @(negedge clk);
    cfg_period = 16'd3; cfg_high = 16'd1; cfg_count = 8'd2;
    start = 1'b1; stop = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      vectors++;
      if ({sysref_out, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL start_stop_idle cycle %0d: got sys/busy/done=%b/%b/%b, expected 0/0/0",
                 k, sysref_out, busy, done);
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [10:0] e;
    logic [10:0] o;
    @(negedge clk);
    cfg_period = 16'd6; cfg_high = 16'd3; cfg_count = 8'd3; start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = 1'b0;
      o = {sysref_out, busy, done, pulse_cnt};
      e = model(k - 1, 6, 3, 3, -1);
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_during_run cycle %0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                 k, o[10], o[9], o[8], o[7:0], e[10], e[9], e[8], e[7:0]);
      end
      if (k - 1 == 5 || k - 1 == 13) begin
        start = 1'b1; cfg_period = 16'd2; cfg_high = 16'd1; cfg_count = 8'd1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    int p;
    int hc;
    int n;
    int s;
    for (int i = 0; i < 20; i++) begin
      p  = int'($urandom_range(0, 12));
      hc = int'($urandom_range(0, 15));
      n  = int'($urandom_range(0, 5));
      if (n == 0 || $urandom_range(0, 2) == 0)
        s = (n == 0) ? int'($urandom_range(0, 60))
                     : int'($urandom_range(0, n * (p + 1) - 1));
      else
        s = -1;
      test_run("random", p, hc, n, s, 1'b1);
    end
  endtask

  task automatic test_reset_midrun();
    int waited;
    @(negedge clk);
    cfg_period = 16'd9; cfg_high = 16'd5; cfg_count = 8'd0; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (sysref_out !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL reset_midrun_wait: sysref_out got %b, expected 1 within 20 cycles",
               sysref_out);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({sysref_out, busy, done, pulse_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_midrun_async: got %b/%b/%b/%0d, expected 0/0/0/0",
               sysref_out, busy, done, pulse_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({sysref_out, busy, done, pulse_cnt} !== 11'd0) begin
        errors++;
        $display("FAIL reset_midrun_after cycle %0d: got %b/%b/%b/%0d, expected 0/0/0/0",
                 k, sysref_out, busy, done, pulse_cnt);
      end
    end
  endtask

`endif

  initial begin
    test_reset();
`ifdef MTS_SYSREF_GEN_ALIGN_EN
    test_align();
    test_align_stop();
`else
    test_run("burst", 9, 2, 3, -1, 1'b0);
    test_run("clamp", 3, 7, 2, -1, 1'b0);
    test_run("degenerate", 0, 5, 4, -1, 1'b0);
    test_start_stop_idle();
    test_start_during_run();
    test_run("cont_stop", 4, 1, 0, 1500, 1'b0);
    test_run("stop_at_end", 4, 2, 2, 9, 1'b0);
    test_random();
    test_reset_midrun();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
